// File: rtl/timekeeper_pkg.sv
// Purpose : shared FSM encoding, BCD digit limits and MM:SS BCD helpers for the alarm timekeeper.
// Latency : n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: tk_state_t, BCD_UNIT_MAX/BCD_TENS_MAX, idx_width(), bcd_mmss_valid(), bcd_mmss_inc().
package timekeeper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RING   = 2'd1,
      ST_SNOOZE = 2'd2
   } tk_state_t;

   // Units digits (S0, M0) run 0..9; tens digits (S1, M1) run 0..5.
   localparam logic [3:0] BCD_UNIT_MAX = 4'd9;
   localparam logic [3:0] BCD_TENS_MAX = 4'd5;

   // Channel index width; a single channel still gets a 1-bit index.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // {M1,M0,S1,S0} is a legal MM:SS value.
   function automatic logic bcd_mmss_valid(input logic [15:0] t);
      return (t[15:12] <= BCD_TENS_MAX) && (t[11:8] <= BCD_UNIT_MAX) &&
             (t[7:4]   <= BCD_TENS_MAX) && (t[3:0]  <= BCD_UNIT_MAX);
   endfunction

   // One-second increment with digit ripple; 59:59 wraps to 00:00.
   function automatic logic [15:0] bcd_mmss_inc(input logic [15:0] t);
      logic [3:0] m1, m0, s1, s0;
      {m1, m0, s1, s0} = t;
      if (s0 != BCD_UNIT_MAX) begin
         s0 = s0 + 4'd1;
      end else begin
         s0 = 4'd0;
         if (s1 != BCD_TENS_MAX) begin
            s1 = s1 + 4'd1;
         end else begin
            s1 = 4'd0;
            if (m0 != BCD_UNIT_MAX) begin
               m0 = m0 + 4'd1;
            end else begin
               m0 = 4'd0;
               m1 = (m1 != BCD_TENS_MAX) ? m1 + 4'd1 : 4'd0;
            end
         end
      end
      return {m1, m0, s1, s0};
   endfunction

endpackage

// File: rtl/multi_alarm_timekeeper_if.sv
// Purpose : groups the timekeeper's load, alarm-write, control and status signals into one bundle.
// Latency : n/a (wiring only).
// Backpressure: none; every request is accepted in the cycle it is presented.
// Modports: master drives load/alarm-write/ack/snooze and observes status; slave is the timekeeper.
interface multi_alarm_timekeeper_if
   import timekeeper_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int IDXW       = idx_width(NUM_ALARMS)
);
   logic                  load_valid;
   logic [15:0]           load_time;
   logic                  load_err;
   logic                  alm_wr_valid;
   logic [IDXW-1:0]       alm_wr_idx;
   logic [15:0]           alm_wr_time;
   logic                  alm_wr_arm;
   logic                  ack;
   logic                  snooze;
   logic [15:0]           cur_time;
   logic                  tick_out;
   logic                  ringing;
   logic [IDXW-1:0]       ring_idx;
   logic [NUM_ALARMS-1:0] alarm_armed;

   modport master (
      output load_valid, load_time, alm_wr_valid, alm_wr_idx, alm_wr_time, alm_wr_arm, ack, snooze,
      input  load_err, cur_time, tick_out, ringing, ring_idx, alarm_armed
   );

   modport slave (
      input  load_valid, load_time, alm_wr_valid, alm_wr_idx, alm_wr_time, alm_wr_arm, ack, snooze,
      output load_err, cur_time, tick_out, ringing, ring_idx, alarm_armed
   );
endinterface

// File: rtl/bcd_mmss_counter.sv
// Purpose : 1 s prescaler plus MM:SS BCD time register with validated load.
// Latency : cur_time/tick/load_err registered, 1 cycle after the causing edge condition.
// Backpressure: none; a valid load always wins over a same-cycle tick and restarts the prescaler.
// Ports   : clk, reset (async high); load_valid/load_time in; load_err, cur_time, tick out.
module bcd_mmss_counter
   import timekeeper_pkg::*;
#(
   parameter int TICK_DIV = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_valid,
   input  logic [15:0] load_time,
   output logic        load_err,
   output logic [15:0] cur_time,
   output logic        tick
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_cnt;
   logic          pre_tc;
   logic          load_ok;

   assign pre_tc  = (pre_cnt == PRE_LAST);
   assign load_ok = load_valid && bcd_mmss_valid(load_time);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt  <= '0;
         cur_time <= '0;
         tick     <= 1'b0;
         load_err <= 1'b0;
      end else begin
         load_err <= load_valid && !load_ok;
         // A load suppresses the tick so a freshly loaded time never looks like an increment.
         tick     <= pre_tc && !load_ok;
         if (load_ok) begin
            cur_time <= load_time;
            pre_cnt  <= '0;
         end else if (pre_tc) begin
            cur_time <= bcd_mmss_inc(cur_time);
            pre_cnt  <= '0;
         end else begin
            pre_cnt  <= pre_cnt + PW'(1);
         end
      end
   end
endmodule

// File: rtl/multi_alarm_timekeeper.sv
// Purpose : MM:SS timekeeper with NUM_ALARMS armed alarm channels, ring timeout and optional snooze.
// Latency : ringing rises 1 cycle after the tick_out whose new time matched; alarm writes visible next cycle.
// Backpressure: none; ack/snooze are single-cycle pulses, matches while RING/SNOOZE are dropped.
// Ports   : clk, reset (async high); bus = multi_alarm_timekeeper_if.slave.
// Config  : define SNOOZE_EN to build the SNOOZE state; otherwise the snooze input is ignored.
module multi_alarm_timekeeper
   import timekeeper_pkg::*;
#(
   parameter int TICK_DIV     = 1,
   parameter int NUM_ALARMS   = 4,
   parameter int RING_TIMEOUT = 30,
   parameter int SNOOZE_SEC   = 60
) (
   input logic                     clk,
   input logic                     reset,
   multi_alarm_timekeeper_if.slave bus
);
   localparam int IDXW    = idx_width(NUM_ALARMS);
   localparam int SEC_MAX = (RING_TIMEOUT > SNOOZE_SEC) ? RING_TIMEOUT : SNOOZE_SEC;
   localparam int SW      = $clog2(SEC_MAX + 1);
   localparam logic [SW-1:0] RING_LAST = SW'(RING_TIMEOUT - 1);
`ifdef SNOOZE_EN
   localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_SEC - 1);
`endif

   logic [15:0]                 cur_time;
   logic                        tick;
   logic                        load_err;
   logic [NUM_ALARMS-1:0][15:0] alm_time;
   logic [NUM_ALARMS-1:0]       alm_arm;
   logic                        hit;
   logic [IDXW-1:0]             hit_idx;
   tk_state_t                   state, state_nx;
   logic [SW-1:0]               sec_cnt, sec_nx;
   logic [IDXW-1:0]             ring_idx, ring_idx_nx;

   bcd_mmss_counter #(.TICK_DIV(TICK_DIV)) u_counter (
      .clk        (clk),
      .reset      (reset),
      .load_valid (bus.load_valid),
      .load_time  (bus.load_time),
      .load_err   (load_err),
      .cur_time   (cur_time),
      .tick       (tick)
   );

   // Alarm register file.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alm_time <= '0;
         alm_arm  <= '0;
      end else if (bus.alm_wr_valid) begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (bus.alm_wr_idx == IDXW'(i)) begin
               alm_time[i] <= bus.alm_wr_time;
               alm_arm[i]  <= bus.alm_wr_arm;
            end
         end
      end
   end

   // Priority match: scanning downwards leaves the lowest matching channel.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (alm_arm[i] && (alm_time[i] == cur_time)) begin
            hit     = 1'b1;
            hit_idx = IDXW'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         sec_cnt  <= '0;
         ring_idx <= '0;
      end else begin
         state    <= state_nx;
         sec_cnt  <= sec_nx;
         ring_idx <= ring_idx_nx;
      end
   end

   // tick is high in the cycle cur_time shows the new second, so matching on it
   // lands RING exactly one cycle after tick_out. Loads never raise tick.
   always_comb begin
      state_nx    = state;
      sec_nx      = sec_cnt;
      ring_idx_nx = ring_idx;
      unique case (state)
         ST_IDLE: begin
            if (tick && hit) begin
               state_nx    = ST_RING;
               sec_nx      = '0;
               ring_idx_nx = hit_idx;
            end
         end
         ST_RING: begin
            if (bus.ack) begin
               state_nx = ST_IDLE;
               sec_nx   = '0;
`ifdef SNOOZE_EN
            end else if (bus.snooze) begin
               state_nx = ST_SNOOZE;
               sec_nx   = '0;
`endif
            end else if (tick) begin
               if (sec_cnt == RING_LAST) begin
                  state_nx = ST_IDLE;
                  sec_nx   = '0;
               end else begin
                  sec_nx   = sec_cnt + SW'(1);
               end
            end
         end
`ifdef SNOOZE_EN
         ST_SNOOZE: begin
            if (bus.ack) begin
               state_nx = ST_IDLE;
               sec_nx   = '0;
            end else if (tick) begin
               if (sec_cnt == SNOOZE_LAST) begin
                  state_nx = ST_RING;
                  sec_nx   = '0;
               end else begin
                  sec_nx   = sec_cnt + SW'(1);
               end
            end
         end
`endif
         default: begin
            state_nx = ST_IDLE;
            sec_nx   = '0;
         end
      endcase
   end

`ifndef SNOOZE_EN
   logic unused_snooze;
   assign unused_snooze = bus.snooze;
`endif

   assign bus.cur_time    = cur_time;
   assign bus.tick_out    = tick;
   assign bus.load_err    = load_err;
   assign bus.ringing     = (state == ST_RING);
   assign bus.ring_idx    = ring_idx;
   assign bus.alarm_armed = alm_arm;
endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
// Purpose : self-checking bench for multi_alarm_timekeeper (TICK_DIV=4, 4 channels, timeout 3, snooze 2).
// Latency : n/a.
// Backpressure: n/a.
// Reference model keeps time as plain seconds and the alarm state as simple flags; snooze paths follow SNOOZE_EN.
module tb_multi_alarm_timekeeper;
   localparam int TICK_DIV     = 4;
   localparam int NUM_ALARMS   = 4;
   localparam int RING_TIMEOUT = 3;
   localparam int SNOOZE_SEC   = 2;
   localparam int IDXW         = 2;
`ifdef SNOOZE_EN
   localparam bit SNZ = 1'b1;
`else
   localparam bit SNZ = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   multi_alarm_timekeeper_if #(.NUM_ALARMS(NUM_ALARMS), .IDXW(IDXW)) bus ();

   multi_alarm_timekeeper #(
      .TICK_DIV     (TICK_DIV),
      .NUM_ALARMS   (NUM_ALARMS),
      .RING_TIMEOUT (RING_TIMEOUT),
      .SNOOZE_SEC   (SNOOZE_SEC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total  = 0;
   int passes = 0;

   // Reference model state.
   int          m_secs, m_pre, m_cnt, m_idx;
   bit          m_tick, m_err, m_ring, m_snz;
   logic [15:0] m_alm [NUM_ALARMS];
   bit          m_arm [NUM_ALARMS];

   function automatic logic [15:0] to_bcd(input int s);
      int m, x;
      m = s / 60;
      x = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   function automatic bit bcd_ok(input logic [15:0] t);
      return (t[15:12] < 6) && (t[11:8] < 10) && (t[7:4] < 6) && (t[3:0] < 10);
   endfunction

   function automatic int bcd_secs(input logic [15:0] t);
      return 600 * int'(t[15:12]) + 60 * int'(t[11:8]) + 10 * int'(t[7:4]) + int'(t[3:0]);
   endfunction

   function automatic logic [NUM_ALARMS-1:0] armed_vec();
      logic [NUM_ALARMS-1:0] v;
      for (int i = 0; i < NUM_ALARMS; i++) v[i] = m_arm[i];
      return v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_secs = 0; m_pre = 0; m_cnt = 0; m_idx = 0;
      m_tick = 0; m_err = 0; m_ring = 0; m_snz = 0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         m_alm[i] = '0;
         m_arm[i] = 0;
      end
   endtask

   // Advance the model across one rising edge using the inputs currently applied.
   task automatic model_edge();
      int  hit;
      bit  ld_ok;
      hit = -1;
      if (m_tick && !m_ring && !m_snz)
         for (int i = NUM_ALARMS - 1; i >= 0; i--)
            if (m_arm[i] && m_alm[i] == to_bcd(m_secs)) hit = i;
      if (hit >= 0) begin
         m_ring = 1; m_cnt = 0; m_idx = hit;
      end else if (m_ring) begin
         if (bus.ack) m_ring = 0;
         else if (SNZ && bus.snooze) begin
            m_ring = 0; m_snz = 1; m_cnt = 0;
         end else if (m_tick) begin
            m_cnt++;
            if (m_cnt == RING_TIMEOUT) m_ring = 0;
         end
      end else if (m_snz) begin
         if (bus.ack) m_snz = 0;
         else if (m_tick) begin
            m_cnt++;
            if (m_cnt == SNOOZE_SEC) begin
               m_snz = 0; m_ring = 1; m_cnt = 0;
            end
         end
      end
      if (bus.alm_wr_valid) begin
         m_alm[bus.alm_wr_idx] = bus.alm_wr_time;
         m_arm[bus.alm_wr_idx] = bus.alm_wr_arm;
      end
      ld_ok = bus.load_valid && bcd_ok(bus.load_time);
      m_err = bus.load_valid && !ld_ok;
      if (ld_ok) begin
         m_secs = bcd_secs(bus.load_time); m_pre = 0; m_tick = 0;
      end else if (m_pre == TICK_DIV - 1) begin
         m_secs = (m_secs + 1) % 3600; m_pre = 0; m_tick = 1;
      end else begin
         m_pre++; m_tick = 0;
      end
   endtask

   task automatic check_all();
      chk("cur_time",    32'(bus.cur_time),    32'(to_bcd(m_secs)));
      chk("tick_out",    32'(bus.tick_out),    32'(m_tick));
      chk("load_err",    32'(bus.load_err),    32'(m_err));
      chk("ringing",     32'(bus.ringing),     32'(m_ring));
      chk("alarm_armed", 32'(bus.alarm_armed), 32'(armed_vec()));
      if (m_ring || m_snz) chk("ring_idx", 32'(bus.ring_idx), 32'(m_idx));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic clear_inputs();
      bus.load_valid = 0; bus.load_time = '0;
      bus.alm_wr_valid = 0; bus.alm_wr_idx = '0; bus.alm_wr_time = '0; bus.alm_wr_arm = 0;
      bus.ack = 0; bus.snooze = 0;
   endtask

   // Program ch1 = 00:05 armed, load 00:04, wait for the tick that reaches 00:05, then one more cycle.
   task automatic arm_and_ring();
      bus.alm_wr_valid = 1; bus.alm_wr_idx = 2'd1; bus.alm_wr_time = 16'h0005; bus.alm_wr_arm = 1;
      step();
      bus.alm_wr_valid = 0;
      bus.load_valid = 1; bus.load_time = 16'h0004;
      step();
      bus.load_valid = 0;
      for (int i = 0; i < TICK_DIV + 2 && bus.tick_out !== 1'b1; i++) step();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      reset = 1;
      clear_inputs();
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_time",  32'(bus.cur_time), 32'h0);
      chk("rst_ring",  32'(bus.ringing), 32'h0);
      chk("rst_armed", 32'(bus.alarm_armed), 32'h0);
      check_all();
      reset = 0;

      // Load 59:58 then watch two ticks including the wrap.
      bus.load_valid = 1; bus.load_time = 16'h5958;
      step();
      bus.load_valid = 0;
      chk("load_5958", 32'(bus.cur_time), 32'h5958);
      repeat (4) step();
      chk("tick_5959", 32'(bus.cur_time), 32'h5959);
      chk("tick_pulse1", 32'(bus.tick_out), 32'h1);
      repeat (4) step();
      chk("wrap_0000", 32'(bus.cur_time), 32'h0000);
      chk("tick_pulse2", 32'(bus.tick_out), 32'h1);

      // Invalid loads leave time alone and pulse load_err.
      bus.load_valid = 1; bus.load_time = 16'h6A00;
      step();
      chk("err_6A00", 32'(bus.load_err), 32'h1);
      chk("err_6A00_time", 32'(bus.cur_time), 32'h0000);
      bus.load_time = 16'h1275;
      step();
      bus.load_valid = 0;
      chk("err_1275", 32'(bus.load_err), 32'h1);
      chk("err_1275_time", 32'(bus.cur_time), 32'h0000);
      step();

      // Load coinciding with the prescaler terminal count.
      for (int i = 0; i < 2 * TICK_DIV && m_pre != TICK_DIV - 1; i++) step();
      bus.load_valid = 1; bus.load_time = 16'h1234;
      step();
      bus.load_valid = 0;
      chk("ldtick_time", 32'(bus.cur_time), 32'h1234);
      chk("ldtick_tick", 32'(bus.tick_out), 32'h0);
      repeat (TICK_DIV - 1) step();
      chk("ldtick_hold", 32'(bus.cur_time), 32'h1234);
      step();
      chk("ldtick_next", 32'(bus.cur_time), 32'h1235);

      // Two channels on the same time: lowest index fires.
      bus.alm_wr_valid = 1; bus.alm_wr_idx = 2'd2; bus.alm_wr_time = 16'h0005; bus.alm_wr_arm = 1;
      step();
      chk("armed_ch2", 32'(bus.alarm_armed), 32'h4);
      arm_and_ring();
      chk("ring_on", 32'(bus.ringing), 32'h1);
      chk("ring_idx1", 32'(bus.ring_idx), 32'h1);

      // No ack: ring times out after RING_TIMEOUT seconds.
      n = 0;
      for (int i = 0; i < 40 && bus.ringing === 1'b1; i++) begin
         step();
         n++;
      end
      chk("ring_timeout", 32'(bus.ringing), 32'h0);
      chk("ring_len", 32'(n), 32'(RING_TIMEOUT * TICK_DIV));
      chk("still_armed", 32'(bus.alarm_armed), 32'h6);

      arm_and_ring();
      chk("ring_again", 32'(bus.ringing), 32'h1);
`ifdef SNOOZE_EN
      bus.snooze = 1;
      step();
      bus.snooze = 0;
      chk("snz_off", 32'(bus.ringing), 32'h0);
      for (int i = 0; i < 40 && bus.ringing !== 1'b1; i++) step();
      chk("rering", 32'(bus.ringing), 32'h1);
      chk("rering_idx", 32'(bus.ring_idx), 32'h1);
      bus.ack = 1; bus.snooze = 1;
      step();
      bus.ack = 0; bus.snooze = 0;
      chk("acksnz_off", 32'(bus.ringing), 32'h0);
      repeat (3 * TICK_DIV) step();
      chk("acksnz_idle", 32'(bus.ringing), 32'h0);
`else
      bus.snooze = 1;
      step();
      bus.snooze = 0;
      chk("snz_ignored", 32'(bus.ringing), 32'h1);
      bus.ack = 1;
      step();
      bus.ack = 0;
      chk("ack_off", 32'(bus.ringing), 32'h0);
`endif

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         bus.load_valid = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 3) == 0) bus.load_time = 16'($urandom);
         else bus.load_time = to_bcd(int'($urandom_range(0, 3599)));
         bus.alm_wr_valid = ($urandom_range(0, 9) == 0);
         bus.alm_wr_idx   = 2'($urandom_range(0, NUM_ALARMS - 1));
         bus.alm_wr_time  = to_bcd((m_secs + int'($urandom_range(1, 4))) % 3600);
         bus.alm_wr_arm   = ($urandom_range(0, 3) != 0);
         bus.ack          = ($urandom_range(0, 24) == 0);
         bus.snooze       = ($urandom_range(0, 9) == 0);
         step();
      end
      clear_inputs();

      // Async reset while ringing.
      bus.ack = 1;
      step();
      bus.ack = 0;
      arm_and_ring();
      chk("pre_rst_ring", 32'(bus.ringing), 32'h1);
      #2 reset = 1;
      #1;
      chk("arst_ring",  32'(bus.ringing), 32'h0);
      chk("arst_time",  32'(bus.cur_time), 32'h0000);
      chk("arst_armed", 32'(bus.alarm_armed), 32'h0);
      model_reset();
      @(negedge clk);
      reset = 0;
      check_all();
      repeat (6) step();

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
